// File: rtl/upsample_read_scheduler.sv
// -----------------------------------------------------------------------------
// upsample_read_scheduler
//
// Read-side sequencer for the x2 vertical upsample FIFO. Every buffered input
// row is emitted twice: first non-destructively on the FIFO virtual read
// pointer, then again on the real pointer, which pops it. Between the two
// passes the FIFO pointer_select is toggled and one settle cycle lets the
// FIFO output register present the real-pointer word.
//
// Ports
//   system_clk         clock
//   rst                asynchronous, active-high reset
//   start              one-cycle pulse; latches row_words/row_count, begins layer
//   row_words          128-bit words per input row (1..2047)
//   row_count          input rows in the layer
//   ds_ready           downstream can accept a word this cycle
//   fifo_almost_empty  FIFO count < threshold (a full row is not yet buffered)
//   fifo_empty         FIFO has no word on the selected pointer
//   fifo_rden          FIFO read enable / pop
//   fifo_change_point  one-cycle pulse toggling FIFO pointer_select
//   fifo_threshold     FIFO almost_empty_threshold (latched row_words)
//   out_valid          FIFO o_rddata is a valid output word (same as fifo_rden)
//   out_pass           0 = first copy of the row, 1 = second copy
//   out_last           last word of the last output row
//   busy               layer in progress
//   done               one-cycle pulse at layer end
// -----------------------------------------------------------------------------
module upsample_read_scheduler #(
   parameter int ROW_W = 11,
   parameter int CNT_W = 10
) (
   input  logic             system_clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ROW_W-1:0] row_words,
   input  logic [CNT_W-1:0] row_count,
   input  logic             ds_ready,
   input  logic             fifo_almost_empty,
   input  logic             fifo_empty,
   output logic             fifo_rden,
   output logic             fifo_change_point,
   output logic [ROW_W-1:0] fifo_threshold,
   output logic             out_valid,
   output logic             out_pass,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_PASS0,
      S_SW0,
      S_SETTLE0,
      S_PASS1,
      S_SW1,
      S_DONE
   } state_e;

   state_e           state_q,    state_d;
   logic [ROW_W-1:0] words_q,    words_d;     // latched row_words
   logic [CNT_W-1:0] rows_q,     rows_d;      // latched row_count
   logic [ROW_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] row_cnt_q,  row_cnt_d;
   logic             sel_q,      sel_d;       // mirror of FIFO pointer_select

   logic last_word;
   logic last_row;
   logic rd_en;

   // Latched config is never zero once a pass is entered, so the -1 cannot
   // underflow where these compares matter.
   assign last_word = (word_cnt_q == words_q - ROW_W'(1));
   assign last_row  = (row_cnt_q  == rows_q  - CNT_W'(1));

   // NOTE: every signal written here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d           = state_q;
      words_d           = words_q;
      rows_d            = rows_q;
      word_cnt_d        = word_cnt_q;
      row_cnt_d         = row_cnt_q;
      sel_d             = sel_q;
      rd_en             = 1'b0;
      fifo_change_point = 1'b0;
      done              = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               words_d    = row_words;
               rows_d     = row_count;
               word_cnt_d = '0;
               row_cnt_d  = '0;
               state_d    = S_WAIT;
            end
         end

         // A zero-sized layer is detected here, on the latched config, so it
         // costs the same fixed 2-cycle overhead as a real layer.
         S_WAIT: begin
            if (words_q == '0 || rows_q == '0) begin
               state_d = S_DONE;
            end else if (!fifo_almost_empty) begin
               word_cnt_d = '0;
               state_d    = S_PASS0;
            end
         end

         // Both passes share the read rule; a stall simply holds word_cnt.
         S_PASS0, S_PASS1: begin
            rd_en = ds_ready & ~fifo_empty;
            if (rd_en) begin
               if (last_word) begin
                  word_cnt_d = '0;
                  state_d    = (state_q == S_PASS0) ? S_SW0 : S_SW1;
               end else begin
                  word_cnt_d = word_cnt_q + ROW_W'(1);
               end
            end
         end

         S_SW0: begin
            fifo_change_point = 1'b1;
            sel_d             = ~sel_q;
            state_d           = S_SETTLE0;
         end

         // Idle cycle: FIFO output register reloads from the real pointer.
         S_SETTLE0: begin
            word_cnt_d = '0;
            state_d    = S_PASS1;
         end

         // When the next row is already buffered, skip WAIT so the row gap
         // is exactly this one cycle.
         S_SW1: begin
            fifo_change_point = 1'b1;
            sel_d             = ~sel_q;
            row_cnt_d         = row_cnt_q + CNT_W'(1);
            if (last_row) begin
               state_d = S_DONE;
            end else if (fifo_almost_empty) begin
               state_d = S_WAIT;
            end else begin
               word_cnt_d = '0;
               state_d    = S_PASS0;
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge system_clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         words_q    <= '0;
         rows_q     <= '0;
         word_cnt_q <= '0;
         row_cnt_q  <= '0;
         sel_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         words_q    <= words_d;
         rows_q     <= rows_d;
         word_cnt_q <= word_cnt_d;
         row_cnt_q  <= row_cnt_d;
         sel_q      <= sel_d;
      end
   end

   // Read data is first-word-fall-through, so the word is valid with rden.
   assign fifo_rden      = rd_en;
   assign out_valid      = rd_en;
   assign out_pass       = (state_q == S_PASS1);
   assign out_last       = rd_en && (state_q == S_PASS1) && last_word && last_row;
   assign busy           = (state_q != S_IDLE);
   assign fifo_threshold = words_q;

endmodule

// File: tb/tb_upsample_read_scheduler.sv
// -----------------------------------------------------------------------------
// tb_upsample_read_scheduler
//
// Self-checking bench. A behavioural dual-pointer FIFO feeds the scheduler;
// the expected output stream of each layer is built from the row/pass rules
// (each row twice, pass 0 then pass 1) and compared word by word.
// -----------------------------------------------------------------------------
module tb_upsample_read_scheduler;

   localparam int ROW_W = 11;
   localparam int CNT_W = 10;

   logic             system_clk = 1'b0;
   logic             rst;
   logic             start;
   logic [ROW_W-1:0] row_words;
   logic [CNT_W-1:0] row_count;
   logic             ds_ready;
   logic             fifo_almost_empty;
   logic             fifo_empty;
   logic             fifo_rden;
   logic             fifo_change_point;
   logic [ROW_W-1:0] fifo_threshold;
   logic             out_valid;
   logic             out_pass;
   logic             out_last;
   logic             busy;
   logic             done;

   always #5 system_clk = ~system_clk;

   upsample_read_scheduler #(.ROW_W(ROW_W), .CNT_W(CNT_W)) dut (
      .system_clk        (system_clk),
      .rst               (rst),
      .start             (start),
      .row_words         (row_words),
      .row_count         (row_count),
      .ds_ready          (ds_ready),
      .fifo_almost_empty (fifo_almost_empty),
      .fifo_empty        (fifo_empty),
      .fifo_rden         (fifo_rden),
      .fifo_change_point (fifo_change_point),
      .fifo_threshold    (fifo_threshold),
      .out_valid         (out_valid),
      .out_pass          (out_pass),
      .out_last          (out_last),
      .busy              (busy),
      .done              (done)
   );

   // ---------------- behavioural FIFO with virtual/real read pointers -------
   int unsigned mem [0:4095];
   int unsigned wptr, rptr_real, rptr_virt, rd_ptr, rd_data;
   int unsigned gseq = 0;   // global write sequence number, used as data
   bit          psel;       // 0 = virtual pointer, 1 = real pointer
   logic        wr_en;

   always @(posedge system_clk or posedge rst) begin
      if (rst) begin
         wptr      <= 0;
         rptr_real <= 0;
         rptr_virt <= 0;
         psel      <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wptr % 4096] <= gseq;
            wptr             <= wptr + 1;
            gseq             <= gseq + 1;
         end
         if (fifo_rden) begin
            if (psel) rptr_real <= rptr_real + 1;
            else      rptr_virt <= rptr_virt + 1;
         end
         if (fifo_change_point) psel <= ~psel;
      end
   end

   always_comb begin
      rd_ptr            = psel ? rptr_real : rptr_virt;
      rd_data           = mem[rd_ptr % 4096];
      fifo_empty        = (rd_ptr == wptr);
      fifo_almost_empty = ((wptr - rptr_real) < 32'(fifo_threshold));
   end

   // ---------------- monitor (samples on the falling edge) ------------------
   typedef struct {
      int unsigned data;
      bit          pass;
      bit          last;
   } word_t;

   word_t  obs[$];
   longint cyc = 0;
   longint done_cyc = 0;
   int     cp_cnt = 0, done_cnt = 0, viol_cnt = 0, rden_cnt = 0;
   int     p1_cyc = 0, p1_rd = 0;

   always @(posedge system_clk) cyc <= cyc + 1;

   always @(negedge system_clk) begin
      if (out_valid) obs.push_back('{rd_data, out_pass, out_last});
      if (fifo_rden) rden_cnt++;
      if (fifo_change_point) cp_cnt++;
      if (out_pass) p1_cyc++;
      if (out_valid && out_pass) p1_rd++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if ((out_valid != fifo_rden) || (fifo_rden && (fifo_empty || !ds_ready)) ||
          (out_last && !fifo_rden))
         viol_cnt++;
   end

   // ---------------- checking ----------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge system_clk);
      #1;
   endtask

   // ---------------- layer context ------------------------------------------
   int          lay_rw, lay_rc;
   int unsigned lay_base;
   int          snap_obs, snap_cp, snap_done, snap_viol, snap_rden, snap_p1c, snap_p1rd;
   longint      start_cyc;

   task automatic prep(input int rw, input int rc);
      lay_rw    = rw;
      lay_rc    = rc;
      lay_base  = gseq;
      snap_obs  = obs.size();
      snap_cp   = cp_cnt;
      snap_done = done_cnt;
      snap_viol = viol_cnt;
      snap_rden = rden_cnt;
      snap_p1c  = p1_cyc;
      snap_p1rd = p1_rd;
   endtask

   task automatic prefill(input int n);
      wr_en = 1'b1;
      repeat (n) tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start(input int rw, input int rc);
      row_words = ROW_W'(rw);
      row_count = CNT_W'(rc);
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start     = 1'b0;
      // Config must only be sampled on start; scramble it afterwards.
      row_words = ROW_W'($urandom);
      row_count = CNT_W'($urandom);
      check("busy_after_start", busy, 1);
   endtask

   task automatic run_to_done(input bit prefilled, input bit rand_ready,
                              input bit bp_pass1, input bit restart_mid);
      int to_write;
      int budget;
      int k;
      bit ph;
      to_write = prefilled ? 0 : lay_rw * lay_rc;
      budget   = 5000;
      k        = 0;
      ph       = 1'b0;
      while (done_cnt == snap_done && budget > 0) begin
         wr_en = (to_write > 0) && ($urandom_range(0, 2) != 0);
         if (wr_en) to_write--;
         ds_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (bp_pass1 && out_pass) begin
            ds_ready = ph;
            ph       = ~ph;
         end
         if (restart_mid && k == 5) begin
            start     = 1'b1;
            row_words = ROW_W'(lay_rw + 3);
            row_count = CNT_W'(lay_rc + 1);
         end else begin
            start = 1'b0;
         end
         tick();
         k++;
         budget--;
      end
      wr_en    = 1'b0;
      start    = 1'b0;
      ds_ready = 1'b1;
      check("done_within_budget", budget > 0, 1);
      tick();
      tick();
   endtask

   task automatic end_layer(input string tag, input bit exact);
      int  n_exp;
      int  idx;
      int  f0;
      bit  bad;
      bit  degen;
      int unsigned e_data;
      bit  e_last;
      degen = (lay_rw == 0 || lay_rc == 0);
      n_exp = degen ? 0 : 2 * lay_rw * lay_rc;
      check({tag, "_word_count"}, obs.size() - snap_obs, n_exp);
      if (obs.size() - snap_obs == n_exp) begin
         idx = snap_obs;
         bad = 1'b0;
         for (int r = 0; r < lay_rc && !degen; r++)
            for (int p = 0; p < 2; p++)
               for (int w = 0; w < lay_rw; w++) begin
                  if (!bad) begin
                     e_data = lay_base + r * lay_rw + w;
                     e_last = (p == 1) && (r == lay_rc - 1) && (w == lay_rw - 1);
                     f0 = n_fail;
                     check({tag, "_data"}, obs[idx].data, e_data);
                     check({tag, "_pass"}, obs[idx].pass, p);
                     check({tag, "_last"}, obs[idx].last, e_last);
                     if (n_fail != f0) bad = 1'b1;
                  end
                  idx++;
               end
      end
      check({tag, "_change_points"}, cp_cnt - snap_cp, degen ? 0 : 2 * lay_rc);
      check({tag, "_done_pulses"}, done_cnt - snap_done, 1);
      check({tag, "_protocol"}, viol_cnt - snap_viol, 0);
      check({tag, "_fifo_empty"}, wptr - rptr_real, 0);
      check({tag, "_ptrs_equal"}, rptr_virt - rptr_real, 0);
      check({tag, "_sel_home"}, psel, 0);
      check({tag, "_threshold"}, fifo_threshold, lay_rw);
      check({tag, "_idle"}, {busy, out_valid, done}, 0);
      if (exact)
         check({tag, "_latency"}, done_cyc - start_cyc,
               degen ? 2 : lay_rc * (2 * lay_rw + 3) + 2);
   endtask

   // ---------------- stimulus -----------------------------------------------
   initial begin
      int n;
      int rw;
      int rc;
      bit fast;

      rst       = 1'b1;
      start     = 1'b0;
      wr_en     = 1'b0;
      ds_ready  = 1'b1;
      row_words = '0;
      row_count = '0;
      repeat (3) @(posedge system_clk);
      #1;
      check("reset_outputs",
            {fifo_rden, fifo_change_point, out_valid, out_pass, out_last, busy, done}, 0);
      check("reset_threshold", fifo_threshold, 0);
      rst = 1'b0;
      tick();

      // Two pre-filled rows of four words, full throughput.
      prep(4, 2);
      prefill(8);
      pulse_start(4, 2);
      run_to_done(1'b1, 1'b0, 1'b0, 1'b0);
      end_layer("basic", 1'b1);

      // Starvation: a partial row must not be read.
      prep(8, 1);
      prefill(5);
      pulse_start(8, 1);
      repeat (10) tick();
      check("starve_no_rden", rden_cnt - snap_rden, 0);
      check("starve_busy", busy, 1);
      wr_en = 1'b1;
      repeat (3) tick();
      wr_en = 1'b0;
      n = 0;
      while (!fifo_rden && n < 4) begin
         tick();
         n++;
      end
      check("starve_resume_cycles", n, 1);
      run_to_done(1'b1, 1'b0, 1'b0, 1'b0);
      end_layer("starve", 1'b0);

      // Backpressure on every other cycle of the second pass.
      prep(4, 1);
      prefill(4);
      pulse_start(4, 1);
      run_to_done(1'b1, 1'b0, 1'b1, 1'b0);
      end_layer("bp", 1'b0);
      check("bp_pass1_cycles", p1_cyc - snap_p1c, 8);

      // Degenerate configs.
      prep(5, 0);
      pulse_start(5, 0);
      run_to_done(1'b1, 1'b0, 1'b0, 1'b0);
      end_layer("rows0", 1'b1);
      prep(0, 3);
      pulse_start(0, 3);
      run_to_done(1'b1, 1'b0, 1'b0, 1'b0);
      end_layer("words0", 1'b1);

      // Reset in the middle of the second pass, at word 2 of 4.
      prep(4, 1);
      prefill(4);
      pulse_start(4, 1);
      n = 0;
      while (!(fifo_rden && out_pass && (p1_rd - snap_p1rd) == 2) && n < 100) begin
         tick();
         n++;
      end
      check("rst_reached_pass1_word2", n < 100, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_outputs",
            {fifo_rden, fifo_change_point, out_valid, out_pass, out_last, busy, done}, 0);
      check("rst_mid_threshold", fifo_threshold, 0);
      #2 rst = 1'b0;
      tick();
      prep(4, 2);
      prefill(8);
      pulse_start(4, 2);
      run_to_done(1'b1, 1'b0, 1'b0, 1'b0);
      end_layer("after_rst", 1'b1);

      // A second start while busy must be ignored.
      prep(6, 2);
      prefill(12);
      pulse_start(6, 2);
      run_to_done(1'b1, 1'b0, 1'b0, 1'b1);
      end_layer("restart", 1'b1);

      // Randomized layers: exact-timing or trickle-fed with random ready.
      for (int i = 0; i < 10; i++) begin
         rw   = $urandom_range(1, 12);
         rc   = $urandom_range(1, 4);
         fast = 1'($urandom_range(0, 1));
         prep(rw, rc);
         if (fast) prefill(rw * rc);
         pulse_start(rw, rc);
         run_to_done(fast, !fast, 1'b0, 1'b0);
         end_layer("rand", fast);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
